// File: rtl/drawbridge_pkg.sv
// drawbridge_pkg
//   Shared definitions for the bridge lift sequencer: the 4-bit state
//   encodings (also exported on the debug state port), drive-level constants,
//   and a small elaboration-time helper for sizing the shared dwell timer.
package drawbridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_BAR_HOLD = 4'd1,
    ST_WARN     = 4'd2,
    ST_BAR_DN   = 4'd3,
    ST_CLEAR    = 4'd4,
    ST_RAISE    = 4'd5,
    ST_OPEN     = 4'd6,
    ST_LOWER    = 4'd7,
    ST_BAR_UP   = 4'd8,
    ST_FAULT    = 4'd15
  } liftStateT;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bridge_dwell_timer.sv
// bridge_dwell_timer
//   Saturating up-counter that counts cycles since the last clear. The
//   terminal-count flag is raised once the count reaches the runtime
//   threshold, which lets one instance serve dwell periods of different
//   lengths.
// Ports
//   i_clk      clock
//   i_reset    synchronous, active-low reset (count -> 0)
//   i_clear    restart the count at 0 on the next edge
//   i_enable   advance the count by one (stops at MAX_COUNT)
//   i_tcValue  terminal-count threshold
//   o_tc       count >= i_tcValue
module bridge_dwell_timer #(
  parameter int MAX_COUNT = 16,
  parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_tcValue,
  output logic             o_tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_enable && (count != WIDTH'(MAX_COUNT))) begin
      count <= count + 1'b1;
    end
  end

  assign o_tc = (count >= i_tcValue);

endmodule

// File: rtl/bridge_lift_sequencer.sv
// bridge_lift_sequencer
//   Actuator sequencer for the drawbridge: warns, closes the barrier, waits
//   for the deck to empty, raises, holds open, lowers and reopens the barrier.
//   Any motion timeout or inconsistent sensor reading latches FAULT until reset.
// Ports
//   i_clk, i_reset        clock; synchronous active-low reset
//   i_raise_req           controller wants the bridge open
//   i_barrier_req         controller wants the barrier closed
//   i_alert               forces the beacon on
//   i_car_present         deck occupied
//   i_bar_closed_lim / i_bar_open_lim / i_up_lim / i_down_lim   limit switches
//   o_bar_down            barrier drive (1 = lower, 0 = raise)
//   o_motor_up/o_motor_down  bridge motor drives
//   o_beacon              warning lamp
//   o_bridge_open         high only while fully open
//   o_fault               latched fault
//   o_state               current state encoding
//
// state    | meaning
// IDLE     | bridge down, barrier up
// BAR_HOLD | barrier held down on controller request only
// WARN     | beacon-only warning dwell
// BAR_DN   | barrier lowering
// CLEAR    | barrier down, waiting for the deck to empty
// RAISE    | bridge motor driving up
// OPEN     | bridge fully raised, boats may pass
// LOWER    | bridge motor driving down
// BAR_UP   | barrier raising
// FAULT    | everything stopped, barrier down; left only through reset
module bridge_lift_sequencer
  import drawbridge_pkg::*;
#(
  parameter int WARN_CYCLES  = 16,
  parameter int MOVE_TIMEOUT = 1000,
  parameter int BLINK_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_raise_req,
  input  logic       i_barrier_req,
  input  logic       i_alert,
  input  logic       i_car_present,
  input  logic       i_bar_closed_lim,
  input  logic       i_bar_open_lim,
  input  logic       i_up_lim,
  input  logic       i_down_lim,
  output logic       o_bar_down,
  output logic       o_motor_up,
  output logic       o_motor_down,
  output logic       o_beacon,
  output logic       o_bridge_open,
  output logic       o_fault,
  output logic [3:0] o_state
);

  localparam int TIMER_MAX = maxOf(WARN_CYCLES, MOVE_TIMEOUT);
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam int BW        = $clog2(BLINK_CYCLES + 1);

  liftStateT state, nextState;
  logic motionTc, blinkTc, motionClear, blinkClear;
  logic [TW-1:0] motionTcValue;
  logic moving, targetLim, conflict, timeout, enterWarn, inBlink;
  logic blinkPhase, nextBlinkPhase;
  logic nxtBarDown, nxtMotorUp, nxtMotorDown, nxtBeacon, nxtOpen, nxtFault;

  // One timer covers both the warning dwell and motion timeouts; the
  // threshold follows the current state.
  assign motionTcValue = (state == ST_WARN) ? TW'(WARN_CYCLES - 1) : TW'(MOVE_TIMEOUT - 1);
  assign motionClear   = (nextState != state);

  bridge_dwell_timer #(.MAX_COUNT(TIMER_MAX), .WIDTH(TW)) uMotionTimer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (motionClear),
    .i_enable  (ON),
    .i_tcValue (motionTcValue),
    .o_tc      (motionTc)
  );

  // Blink half-period timer; restarted on WARN entry so the pattern always
  // begins with a full dark half-period.
  assign enterWarn  = (nextState == ST_WARN) && (state != ST_WARN);
  assign blinkClear = enterWarn || blinkTc;

  bridge_dwell_timer #(.MAX_COUNT(BLINK_CYCLES), .WIDTH(BW)) uBlinkTimer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (blinkClear),
    .i_enable  (ON),
    .i_tcValue (BW'(BLINK_CYCLES - 1)),
    .o_tc      (blinkTc)
  );

  always_comb begin
    moving    = OFF;
    targetLim = OFF;
    case (state)
      ST_BAR_DN: begin moving = ON; targetLim = i_bar_closed_lim; end
      ST_RAISE:  begin moving = ON; targetLim = i_up_lim;         end
      ST_LOWER:  begin moving = ON; targetLim = i_down_lim;       end
      ST_BAR_UP: begin moving = ON; targetLim = i_bar_open_lim;   end
      default:   ;
    endcase
  end

  assign conflict = (i_up_lim && i_down_lim) || (i_bar_closed_lim && i_bar_open_lim) ||
                    (i_car_present && ((state == ST_RAISE) || (state == ST_OPEN) || (state == ST_LOWER)));
  assign timeout  = moving && motionTc && !targetLim;

  always_comb begin
    nextState = state;
    if (conflict || timeout) begin
      nextState = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE:     if (i_raise_req) nextState = ST_WARN;
                     else if (i_barrier_req) nextState = ST_BAR_HOLD;
        ST_BAR_HOLD: if (i_raise_req) nextState = ST_WARN;
                     else if (!i_barrier_req) nextState = ST_BAR_UP;
        ST_WARN:     if (!i_raise_req) nextState = ST_BAR_UP;
                     else if (motionTc) nextState = ST_BAR_DN;
        // A request drop wins over a limit arriving in the same cycle.
        ST_BAR_DN:   if (!i_raise_req) nextState = ST_BAR_UP;
                     else if (i_bar_closed_lim) nextState = ST_CLEAR;
        ST_CLEAR:    if (!i_raise_req) nextState = ST_BAR_UP;
                     else if (!i_car_present) nextState = ST_RAISE;
        ST_RAISE:    if (i_up_lim) nextState = ST_OPEN;
        ST_OPEN:     if (!i_raise_req) nextState = ST_LOWER;
        ST_LOWER:    if (i_down_lim) nextState = i_barrier_req ? ST_BAR_HOLD : ST_BAR_UP;
        ST_BAR_UP:   if (i_bar_open_lim) nextState = ST_IDLE;
        ST_FAULT:    nextState = ST_FAULT;
        default:     nextState = ST_FAULT;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    inBlink        = (nextState >= ST_WARN) && (nextState <= ST_LOWER);
    nextBlinkPhase = enterWarn ? OFF : (blinkTc ? ~blinkPhase : blinkPhase);
    nxtMotorUp     = (nextState == ST_RAISE);
    nxtMotorDown   = (nextState == ST_LOWER);
    nxtOpen        = (nextState == ST_OPEN);
    nxtFault       = (nextState == ST_FAULT);
    nxtBarDown     = (nextState == ST_BAR_HOLD) || ((nextState >= ST_BAR_DN) && (nextState <= ST_LOWER)) ||
                     nxtFault;
    nxtBeacon      = nxtFault || i_alert || (inBlink && nextBlinkPhase);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state         <= ST_IDLE;
      blinkPhase    <= OFF;
      o_bar_down    <= OFF;
      o_motor_up    <= OFF;
      o_motor_down  <= OFF;
      o_beacon      <= OFF;
      o_bridge_open <= OFF;
      o_fault       <= OFF;
    end else begin
      state         <= nextState;
      blinkPhase    <= nextBlinkPhase;
      o_bar_down    <= nxtBarDown;
      o_motor_up    <= nxtMotorUp;
      o_motor_down  <= nxtMotorDown;
      o_beacon      <= nxtBeacon;
      o_bridge_open <= nxtOpen;
      o_fault       <= nxtFault;
    end
  end

  assign o_state = state;

  motorExclusive: assert property (@(posedge i_clk) disable iff (!i_reset) !(o_motor_up && o_motor_down));

endmodule
